// File: rtl/npc_fetch.sv
// Fetch/next-PC unit: a three-state fetch-issue sequencer.
// It computes the next PC for pc_inc, branch, jump and jr,
// and counts retired instructions.
module npc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  NPC_src,
    input  logic [2:0]  NPC_branch_cond,
    input  logic [15:0] immediate,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    input  logic        alu_zero,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PC_inc,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {StIdle, StFetch, StIssue} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retire_q, retire_d;
    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic        br_taken;
    logic [31:0] next_pc;

    // The low two bits of jr_target are dropped to force word alignment.
    logic        unused_jr_low;
    assign unused_jr_low = ^jr_target[1:0];

    assign pc_plus4  = pc_q + 32'd4;
    assign br_offset = {{14{immediate[15]}}, immediate, 2'b00};

    // Branch decision; condition codes 3-7 behave as no_branch.
    always_comb begin
        br_taken = 1'b0;
        case (NPC_branch_cond)
            3'd1:    br_taken = alu_zero;
            3'd2:    br_taken = ~alu_zero;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-PC select; invalid source codes fall back to PC+4.
    always_comb begin
        next_pc = pc_plus4;
        case (NPC_src)
            3'd1:    next_pc = br_taken ? (pc_plus4 + br_offset) : pc_plus4;
            3'd2:    next_pc = {pc_plus4[31:28], instr_index, 2'b00};
            3'd3:    next_pc = {jr_target[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    // Sequencer next-state: capture in FETCH, retire and advance in ISSUE.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_d = retire_q;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!stall) begin
                    pc_d     = next_pc;
                    retire_d = retire_q + 32'd1;
                    state_d  = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            retire_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign instr_valid = (state_q == StIssue);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign PC_inc      = pc_plus4;
    assign instr       = instr_q;
    assign retire_cnt  = retire_q;

endmodule
